// File: rtl/mitikv_pkg.sv
// Shared constants and types for the MitiKV database request path.
package mitikv_pkg;

    localparam int unsigned KEY_SIZE_DEF  = 96;
    localparam int unsigned TAG_DEPTH_DEF = 8;

    // Operation kind carried in flag[2:1]
    typedef enum logic [1:0] {
        FLAG_NONE     = 2'b00,
        FLAG_SUSPECT  = 2'b01,
        FLAG_ARREST   = 2'b10,
        FLAG_FILTERED = 2'b11
    } db_flag_e;

    typedef enum logic {
        PRI_REQ0 = 1'b0,
        PRI_REQ1 = 1'b1
    } rr_pri_e;

    function automatic db_flag_e flag_kind(input logic [3:0] flag);
        return db_flag_e'(flag[2:1]);
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/db_tag_fifo.sv
// 1-bit-wide synchronous FIFO holding the requester index of each outstanding DB request.
module db_tag_fifo
    import mitikv_pkg::*;
#(
    parameter int unsigned DEPTH = TAG_DEPTH_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_push,
    input  logic                    i_din,
    input  logic                    i_pop,
    output logic                    o_dout,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Full/empty are judged on the pre-update count; pointers wrap as DEPTH is a power of 2
    assign w_do_pop  = i_pop  && (r_count != '0);
    assign w_do_push = i_push && (r_count != FULL_CNT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/db_req_arbiter.sv
// Two-way round-robin arbiter in front of an in-order DB; routes each reply back
// to the requester that issued it using a tag FIFO of requester indices.
module db_req_arbiter
    import mitikv_pkg::*;
#(
    parameter int unsigned KEY_SIZE  = KEY_SIZE_DEF,
    parameter int unsigned TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic                clk156,
    input  logic                eth_rst,
    input  logic                req0_valid,
    input  logic                req1_valid,
    output logic                req0_ready,
    output logic                req1_ready,
    input  logic [KEY_SIZE-1:0] req0_key,
    input  logic [KEY_SIZE-1:0] req1_key,
    input  logic [3:0]          req0_flag,
    input  logic [3:0]          req1_flag,
    output logic                rsp0_valid,
    output logic                rsp1_valid,
    output logic [3:0]          rsp0_flag,
    output logic [3:0]          rsp1_flag,
    output logic [KEY_SIZE-1:0] in_key,
    output logic [3:0]          in_flag,
    output logic                in_valid,
    input  logic                out_valid,
    input  logic [3:0]          out_flag,
    output logic [7:0]          debug
);

    localparam int unsigned     CW       = $clog2(TAG_DEPTH) + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(TAG_DEPTH);

    rr_pri_e             r_pri;
    rr_pri_e             w_pri_nxt;
    logic                r_in_valid;
    logic [KEY_SIZE-1:0] r_in_key;
    logic [3:0]          r_in_flag;
    logic                r_rsp0_valid;
    logic                r_rsp1_valid;
    logic [3:0]          r_rsp0_flag;
    logic [3:0]          r_rsp1_flag;
    logic [3:0]          r_spur_cnt;

    logic                w_can_accept;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_gnt_any;
    logic                w_pop;
    logic                w_spurious;
    logic                w_head;
    logic [CW-1:0]       w_count;
    logic [4:0]          w_occ;
    logic [3:0]          w_occ4;

    // Full check uses the occupancy before any same-cycle pop
    always_comb begin
        w_can_accept = !eth_rst && (w_count < FULL_CNT);
        w_gnt0       = w_can_accept && req0_valid && (!req1_valid || (r_pri == PRI_REQ0));
        w_gnt1       = w_can_accept && req1_valid && (!req0_valid || (r_pri == PRI_REQ1));
        w_pri_nxt    = r_pri;
        if (w_gnt0) begin
            w_pri_nxt = PRI_REQ1;
        end else if (w_gnt1) begin
            w_pri_nxt = PRI_REQ0;
        end
    end

    assign w_gnt_any  = w_gnt0 || w_gnt1;
    assign w_pop      = out_valid && (w_count != '0);
    assign w_spurious = out_valid && (w_count == '0);

    db_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .i_clk   (clk156),
        .i_rst   (eth_rst),
        .i_push  (w_gnt_any),
        .i_din   (w_gnt1),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            r_pri        <= PRI_REQ0;
            r_in_valid   <= 1'b0;
            r_in_key     <= '0;
            r_in_flag    <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_flag  <= '0;
            r_rsp1_flag  <= '0;
            r_spur_cnt   <= '0;
        end else begin
            r_pri      <= w_pri_nxt;
            r_in_valid <= w_gnt_any;
            if (w_gnt0) begin
                r_in_key  <= req0_key;
                r_in_flag <= req0_flag;
            end else if (w_gnt1) begin
                r_in_key  <= req1_key;
                r_in_flag <= req1_flag;
            end
            r_rsp0_valid <= w_pop && !w_head;
            r_rsp1_valid <= w_pop && w_head;
            if (w_pop && !w_head) begin
                r_rsp0_flag <= out_flag;
            end
            if (w_pop && w_head) begin
                r_rsp1_flag <= out_flag;
            end
            if (w_spurious) begin
                r_spur_cnt <= sat_inc4(r_spur_cnt);
            end
        end
    end

    assign w_occ  = 5'(w_count);
    assign w_occ4 = (w_occ > 5'd15) ? 4'hF : w_occ[3:0];

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign in_valid   = r_in_valid;
    assign in_key     = r_in_key;
    assign in_flag    = r_in_flag;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_flag  = r_rsp0_flag;
    assign rsp1_flag  = r_rsp1_flag;
    assign debug      = {r_spur_cnt, w_occ4};

endmodule
